// File: rtl/fpga_bram_bridge.sv
// fpga_bram_bridge: memory-side endpoint of the CPU<->FPGA beat link.
// Optional write-ack responses: define FPGA_BRAM_WR_ACK_EN.
module fpga_bram_bridge #(
  parameter int ADDRESS_DATA_WIDTH = 34,
  parameter int TAG_W              = 2,
  parameter int ADDR_W             = 32,
  parameter int DATA_W             = 64,
  parameter int DEPTH              = 1024
) (
  input  logic                          fpga_clk,
  input  logic                          rst,
  input  logic                          empty_CPU_to_FPGA_FIFO,
  input  logic                          full_FPGA_to_CPU_FIFO,
  output logic                          r_en_CPU_to_FPGA_FIFO,
  output logic                          w_en_FPGA_to_CPU_FIFO,
  inout  wire  [ADDRESS_DATA_WIDTH-1:0] address_data_bus,
  output logic                          bus_dir,
  output logic                          error
);

  localparam int PW    = ADDRESS_DATA_WIDTH - TAG_W;
  localparam int BEATS = DATA_W / PW;
  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [TAG_W-1:0] T_RD  = TAG_W'(1);
  localparam logic [TAG_W-1:0] T_WR  = TAG_W'(2);
  localparam logic [TAG_W-1:0] T_DAT = TAG_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_MEM,
    RD_RESP,
    TURN
`ifdef FPGA_BRAM_WR_ACK_EN
    , ACK
`endif
  } state_t;

`ifdef FPGA_BRAM_WR_ACK_EN
  localparam state_t WR_END = ACK;
`else
  localparam state_t WR_END = IDLE;
`endif

  state_t state_q, state_d;

  logic                          empty;
  logic                          full;
  logic                          pop;
  logic                          push;
  logic [ADDRESS_DATA_WIDTH-1:0] bus_out;
  logic [TAG_W-1:0]              tag;
  logic [PW-1:0]                 head_pl;
  logic [ADDR_W-1:0]             hdr_idx;
  logic                          hdr_oor;
  logic [CW-1:0]                 cnt;
  logic                          last;
  logic [AW-1:0]                 idx_q;
  logic                          oor_q;
  logic [DATA_W-1:0]             wbuf;
  logic [DATA_W-1:0]             wdata;
  logic [DATA_W-1:0]             rdata;
  logic [PW-1:0]                 rd_beat;
  logic                          mem_we;
`ifdef FPGA_BRAM_WR_ACK_EN
  logic                          ack_ok;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  assign empty   = empty_CPU_to_FPGA_FIFO;
  assign full    = full_FPGA_to_CPU_FIFO;
  assign tag     = address_data_bus[ADDRESS_DATA_WIDTH-1 -: TAG_W];
  assign head_pl = address_data_bus[PW-1:0];
  assign hdr_idx = head_pl[ADDR_W-1:0] >> OFF;
  assign hdr_oor = hdr_idx >= ADDR_W'(DEPTH);
  assign last    = cnt == CW'(BEATS - 1);
  assign rd_beat = rdata[cnt*PW +: PW];
  assign mem_we  = (state_q == WR_DATA) && pop && last && !oor_q;

  assign r_en_CPU_to_FPGA_FIFO = pop;
  assign w_en_FPGA_to_CPU_FIFO = push;
  assign address_data_bus = bus_dir ? bus_out : 'z;

  // state register
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: header decode, data beats, response pacing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (tag == T_RD)      state_d = RD_MEM;
          else if (tag == T_WR) state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (!empty) begin
          if (tag != T_DAT) state_d = WR_END;
          else if (last)    state_d = WR_END;
        end
      end
      RD_MEM:  state_d = RD_RESP;
      RD_RESP: if (!full && last) state_d = TURN;
      TURN:    state_d = IDLE;
`ifdef FPGA_BRAM_WR_ACK_EN
      ACK:     if (!full) state_d = TURN;
`endif
      default: state_d = IDLE;
    endcase
  end

  // outputs: pop only in accepting states, drive bus while responding
  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    bus_dir = 1'b0;
    bus_out = '0;
    unique case (state_q)
      IDLE:    pop = !empty;
      WR_DATA: pop = !empty && (tag == T_DAT);
      RD_RESP: begin
        bus_dir = 1'b1;
        push    = !full;
        bus_out = {T_DAT, oor_q ? {PW{1'b0}} : rd_beat};
      end
`ifdef FPGA_BRAM_WR_ACK_EN
      ACK: begin
        bus_dir = 1'b1;
        push    = !full;
        bus_out = {T_WR, {(PW-1){1'b0}}, ack_ok};
      end
`endif
      default: ;
    endcase
  end

  // merge the final data beat with the buffered lower beats
  always_comb begin
    wdata = wbuf;
    wdata[cnt*PW +: PW] = head_pl;
  end

  // datapath: index latch, beat counter, sticky error
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx_q  <= '0;
      oor_q  <= 1'b0;
      wbuf   <= '0;
      error  <= 1'b0;
`ifdef FPGA_BRAM_WR_ACK_EN
      ack_ok <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            if (tag == T_RD || tag == T_WR) begin
              idx_q <= hdr_idx[AW-1:0];
              oor_q <= hdr_oor;
              cnt   <= '0;
              if (hdr_oor) error <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (pop) begin
            wbuf[cnt*PW +: PW] <= head_pl;
            cnt <= last ? '0 : cnt + CW'(1);
`ifdef FPGA_BRAM_WR_ACK_EN
            if (last) ack_ok <= !oor_q;
`endif
          end else if (!empty) begin
            error <= 1'b1;
            cnt   <= '0;
`ifdef FPGA_BRAM_WR_ACK_EN
            ack_ok <= 1'b0;
`endif
          end
        end
        RD_RESP: if (push) cnt <= last ? '0 : cnt + CW'(1);
        default: ;
      endcase
    end
  end

  // BRAM: write on the last data beat, registered read in RD_MEM
  always_ff @(posedge fpga_clk) begin
    if (mem_we) mem[idx_q] <= wdata;
    if (state_q == RD_MEM && !oor_q) rdata <= mem[idx_q];
  end

endmodule

// File: tb/tb_fpga_bram_bridge.sv
// tb_fpga_bram_bridge: directed vectors for fpga_bram_bridge.
// FWFT FIFO model on the shared bus, response capture queue.
module tb_fpga_bram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b1;
  logic        full = 1'b0;
  logic        r_en;
  logic        w_en;
  logic        bus_dir;
  logic        error;
  logic [33:0] head = '0;
  wire  [33:0] bus;

  logic [33:0] q[$];
  logic [33:0] resp[$];
  int          pops[$];
  int          cyc = 0;
  int          t_wen = -1;
  logic        pop_n = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  assign bus = bus_dir ? 34'bz : head;

  fpga_bram_bridge dut (
    .fpga_clk               (clk),
    .rst                    (rst),
    .empty_CPU_to_FPGA_FIFO (empty),
    .full_FPGA_to_CPU_FIFO  (full),
    .r_en_CPU_to_FPGA_FIFO  (r_en),
    .w_en_FPGA_to_CPU_FIFO  (w_en),
    .address_data_bus       (bus),
    .bus_dir                (bus_dir),
    .error                  (error)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void upd();
    empty = (q.size() == 0);
    head  = empty ? '0 : q[0];
  endfunction

  // sample handshakes mid-cycle
  always @(negedge clk) begin
    pop_n = r_en;
    if (r_en) pops.push_back(cyc);
    if (w_en) resp.push_back(bus);
    if (w_en && t_wen < 0) t_wen = cyc;
  end

  // FIFO pop just after the edge that consumed the head
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_n && !rst && q.size() != 0) void'(q.pop_front());
    pop_n = 1'b0;
    upd();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(logic [1:0] t, logic [31:0] p);
    q.push_back({t, p});
    upd();
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(q.size()), 64'd0);
    repeat (8) tick();
  endtask

  task automatic take(output logic [63:0] v);
    v = (resp.size() != 0) ? 64'(resp.pop_front()) : '1;
  endtask

  task automatic exp_beat(string tag, logic [63:0] exp);
    logic [63:0] v;
    take(v);
    check(tag, v, exp);
  endtask

  task automatic exp_ack(string tag, logic [63:0] exp);
`ifdef FPGA_BRAM_WR_ACK_EN
    exp_beat(tag, exp);
`endif
  endtask

  initial begin
    logic [63:0] v;
    int          n;
    int          bad_bus;
    int          bad_wen;
    int          bad_dir;
    logic [3:0]  s_wen;
    logic [3:0]  s_dir;
    logic [3:0]  s_ren;

    repeat (3) tick();
    check("rst_ren", r_en, 0);
    check("rst_wen", w_en, 0);
    check("rst_dir", bus_dir, 0);
    check("rst_err", error, 0);
    rst = 1'b0;
    tick();

    // write two words, read one back and measure latency
    push(2'b10, 32'h40);
    push(2'b11, 32'h55667788);
    push(2'b11, 32'h11223344);
    push(2'b10, 32'h0);
    push(2'b11, 32'h5A5A5A5A);
    push(2'b11, 32'hA5A5A5A5);
    drain("wr_drain");
    exp_ack("wr40_ack", 64'h2_00000001);
    exp_ack("wr0_ack", 64'h2_00000001);
    resp.delete();
    t_wen = -1;
    push(2'b01, 32'h40);
    drain("rd_drain");
    exp_beat("rd40_b0", 64'h3_55667788);
    exp_beat("rd40_b1", 64'h3_11223344);
    check("rd_lat", 64'(t_wen - pops[pops.size()-1]), 64'd2);
    check("rd_err", error, 0);

    // back-pressure on the response FIFO, then turnaround
    resp.delete();
    full = 1'b1;
    push(2'b01, 32'h40);
    push(2'b01, 32'h40);
    n = 0;
    while (!bus_dir && n < 20) begin
      tick();
      n++;
    end
    check("stall_dir0", bus_dir, 1);
    bad_bus = 0;
    bad_wen = 0;
    bad_dir = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus !== 34'h3_55667788) bad_bus++;
      if (w_en !== 1'b0) bad_wen++;
      if (bus_dir !== 1'b1) bad_dir++;
    end
    check("stall_bus", 64'(bad_bus), 0);
    check("stall_wen", 64'(bad_wen), 0);
    check("stall_dir", 64'(bad_dir), 0);
    tick();
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_wen[3-i] = w_en;
      s_dir[3-i] = bus_dir;
      s_ren[3-i] = r_en;
    end
    check("turn_wen", s_wen, 4'b1100);
    check("turn_dir", s_dir, 4'b1100);
    check("turn_ren", s_ren, 4'b0001);
    drain("stall_drain");
    exp_beat("stall_b0", 64'h3_55667788);
    exp_beat("stall_b1", 64'h3_11223344);
    exp_beat("stall2_b0", 64'h3_55667788);
    exp_beat("stall2_b1", 64'h3_11223344);
    check("stall_err", error, 0);

    // header arrives mid-write: abort, then service the read
    resp.delete();
    pops.delete();
    push(2'b10, 32'h40);
    push(2'b11, 32'hDEADBEEF);
    push(2'b01, 32'h40);
    drain("abort_drain");
    exp_ack("abort_ack", 64'h2_00000000);
    exp_beat("abort_b0", 64'h3_55667788);
    exp_beat("abort_b1", 64'h3_11223344);
    check("abort_err", error, 1);
    check("abort_npop", 64'(pops.size()), 64'd3);
`ifdef FPGA_BRAM_WR_ACK_EN
    check("abort_gap", 64'(pops[2] - pops[1]), 64'd4);
`else
    check("abort_gap", 64'(pops[2] - pops[1]), 64'd2);
`endif

    // asynchronous reset in the middle of a response
    resp.delete();
    push(2'b01, 32'h40);
    n = 0;
    while (!w_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_wen", w_en, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_dir", bus_dir, 0);
    check("mid_rst_wen", w_en, 0);
    check("mid_rst_err", error, 0);
    resp.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("mid_noresend", 64'(resp.size()), 64'd0);
    push(2'b01, 32'h40);
    drain("mid_drain");
    exp_beat("mid_b0", 64'h3_55667788);
    exp_beat("mid_b1", 64'h3_11223344);
    check("mid_err", error, 0);

    // out-of-range read, stray tags, out-of-range write
    resp.delete();
    push(2'b01, 32'h2000);
    drain("oor_drain");
    exp_beat("oor_b0", 64'h3_00000000);
    exp_beat("oor_b1", 64'h3_00000000);
    check("oor_err", error, 1);
    push(2'b11, 32'h12345678);
    push(2'b00, 32'h40);
    drain("stray_drain");
    check("stray_resp", 64'(resp.size()), 64'd0);
    check("stray_err", error, 1);
    push(2'b10, 32'h2000);
    push(2'b11, 32'hFFFFFFFF);
    push(2'b11, 32'hFFFFFFFF);
    drain("oorw_drain");
    exp_ack("oorw_ack", 64'h2_00000000);
    resp.delete();
    push(2'b01, 32'h0);
    drain("rd0_drain");
    exp_beat("rd0_b0", 64'h3_5A5A5A5A);
    exp_beat("rd0_b1", 64'h3_A5A5A5A5);
    check("oorw_err", error, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
